// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon memory game sequencer.
// Holds the LFSR step and colour decode helpers used by the game datapath.
package simon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        ADD_STEP,
        SHOW_ON,
        SHOW_OFF,
        WAIT_INPUT,
        WIN,
        LOSE
    } state_t;

    localparam int COLOUR_W = 2;
    localparam int LED_W    = 4;
    localparam int LFSR_W   = 8;
    localparam int CNT_W    = 8;

    localparam int DEF_MAX_LEN       = 32;
    localparam int DEF_ON_TICKS      = 2;
    localparam int DEF_OFF_TICKS     = 1;
    localparam int DEF_TIMEOUT_TICKS = 8;

    localparam logic [LFSR_W-1:0] LFSR_DEFAULT = 8'hA5;

    // Fibonacci step: taps 7,5,4,3, shift left, feedback enters bit 0
    function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [LED_W-1:0] colour_onehot(input logic [COLOUR_W-1:0] c);
        return LED_W'(1) << c;
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit pseudo-random colour source; a zero seed is replaced by the default
// so the register can never lock up in the all-zero state.
module simon_lfsr
    import simon_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            value <= LFSR_DEFAULT;
        end else if (load) begin
            value <= (seed == '0) ? LFSR_DEFAULT : seed;
        end else if (step) begin
            value <= lfsr_advance(value);
        end
    end

endmodule

// File: rtl/simon_sequencer.sv
// Simon game controller: grows a random colour sequence, plays it back on the
// LEDs and checks the player's button presses against it.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int MAX_LEN       = DEF_MAX_LEN,
    parameter int ON_TICKS      = DEF_ON_TICKS,
    parameter int OFF_TICKS     = DEF_OFF_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_game,
    input  logic [7:0]       random_num,
    input  logic             tick,
    input  logic [LED_W-1:0] buttons,
    output logic [LED_W-1:0] led,
    output logic [7:0]       score,
    output logic             game_over,
    output logic             win,
    output logic             busy
);

    localparam int LEN_W = $clog2(MAX_LEN) + 1;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_TICKS - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_TICKS - 1);

    state_t state, state_next;

    logic                start_prev, start_edge;
    logic [7:0]          seed_q;
    logic                lfsr_load, lfsr_step;
    logic [LFSR_W-1:0]   lfsr_value, lfsr_peek;
    logic                unused_peek_bits;
    logic [COLOUR_W-1:0] seq [MAX_LEN];
    logic [LEN_W-1:0]    len, idx, idx_inc;
    logic [CNT_W-1:0]    tick_cnt, timeout;
    logic [LED_W-1:0]    cur_onehot;
    logic                last_step, press_any, press_ok;
    logic                on_done, off_done, timed_out;

    simon_lfsr u_lfsr (
        .clock (clock),
        .reset (reset),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (seed_q),
        .value (lfsr_value)
    );

    assign start_edge       = start_game & ~start_prev;
    assign lfsr_peek        = lfsr_advance(lfsr_value);
    assign unused_peek_bits = ^lfsr_peek[LFSR_W-1:COLOUR_W];
    assign cur_onehot       = colour_onehot(seq[idx[IDX_W-1:0]]);
    assign idx_inc          = idx + LEN_W'(1);
    assign last_step        = (idx_inc == len);
    assign press_any        = |buttons;
    // The one-hot decode has a single bit set, so equality also rejects multi-button presses
    assign press_ok         = (buttons == cur_onehot);
    assign on_done          = tick && (tick_cnt == ON_LAST);
    assign off_done         = tick && (tick_cnt == OFF_LAST);
    assign timed_out        = tick && (timeout == TO_LAST);

    assign game_over = (state == LOSE);
    assign win       = (state == WIN);
    assign busy      = !(state inside {IDLE, WIN, LOSE});

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        led        = '0;
        case (state)
            SEED: begin
                lfsr_load  = 1'b1;
                state_next = ADD_STEP;
            end
            ADD_STEP: begin
                lfsr_step  = 1'b1;
                state_next = SHOW_ON;
            end
            SHOW_ON: begin
                led = cur_onehot;
                if (on_done) state_next = SHOW_OFF;
            end
            SHOW_OFF: begin
                if (off_done) state_next = last_step ? WAIT_INPUT : SHOW_ON;
            end
            WAIT_INPUT: begin
                led = buttons;
                if (press_any) begin
                    if (!press_ok)      state_next = LOSE;
                    else if (last_step) state_next = (len == MAX_LEN_L) ? WIN : ADD_STEP;
                end else if (timed_out) begin
                    state_next = LOSE;
                end
            end
            WIN, LOSE: led = '1;
            default: ;
        endcase
        // A fresh start press overrides whatever the current state wanted
        if (start_edge) begin
            state_next = SEED;
            lfsr_load  = 1'b0;
            lfsr_step  = 1'b0;
            led        = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            start_prev <= 1'b0;
            seed_q     <= '0;
            len        <= '0;
            idx        <= '0;
            score      <= '0;
            tick_cnt   <= '0;
            timeout    <= '0;
        end else begin
            start_prev <= start_game;
            if (start_edge) begin
                seed_q   <= random_num;
                len      <= '0;
                idx      <= '0;
                score    <= '0;
                tick_cnt <= '0;
                timeout  <= '0;
            end else begin
                case (state)
                    ADD_STEP: begin
                        if (len < MAX_LEN_L) len <= len + LEN_W'(1);
                        idx      <= '0;
                        tick_cnt <= '0;
                        timeout  <= '0;
                    end
                    SHOW_ON: begin
                        if (tick) tick_cnt <= on_done ? '0 : tick_cnt + CNT_W'(1);
                    end
                    SHOW_OFF: begin
                        if (off_done) begin
                            tick_cnt <= '0;
                            idx      <= last_step ? '0 : idx_inc;
                        end else if (tick) begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    WAIT_INPUT: begin
                        if (press_any) begin
                            if (press_ok) begin
                                timeout <= '0;
                                idx     <= last_step ? '0 : idx_inc;
                                if (last_step) score <= 8'(len);
                            end
                        end else if (tick) begin
                            timeout <= timeout + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // The new colour is taken from the value the LFSR is about to step to
    always_ff @(posedge clock) begin
        if (state == ADD_STEP && !start_edge && len < MAX_LEN_L) begin
            seq[len[IDX_W-1:0]] <= lfsr_peek[COLOUR_W-1:0];
        end
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed scoreboard bench for simon_sequencer with a four-step game length,
// covering playback timing, scoring, timeout, win, restart and reset.
module tb_simon_sequencer;

    localparam int MAX_LEN = 4;

    logic       clock      = 1'b0;
    logic       reset      = 1'b0;
    logic       start_game = 1'b0;
    logic [7:0] random_num = 8'h00;
    logic       tick       = 1'b0;
    logic [3:0] buttons    = 4'h0;
    logic [3:0] led;
    logic [7:0] score;
    logic       game_over;
    logic       win;
    logic       busy;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t       sb[$];
    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] m_lfsr;
    logic [1:0] colours[$];
    logic [1:0] wrong_colour;

    simon_sequencer #(
        .MAX_LEN       (MAX_LEN),
        .ON_TICKS      (2),
        .OFF_TICKS     (1),
        .TIMEOUT_TICKS (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start_game (start_game),
        .random_num (random_num),
        .tick       (tick),
        .buttons    (buttons),
        .led        (led),
        .score      (score),
        .game_over  (game_over),
        .win        (win),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    task automatic expectOutput(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input logic [7:0] observed);
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("[TB] FAIL scoreboard_empty observed=%0h expected=none", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.val)
            else begin
                mismatched++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, observed, e.val);
            end
        end
    endtask

    // One clock of stimulus; pulses drop back to idle afterwards
    task automatic applyStimulus(input logic st, input logic tk, input logic [3:0] btn);
        start_game = st;
        tick       = tk;
        buttons    = btn;
        @(posedge clock);
        #1;
        start_game = 1'b0;
        tick       = 1'b0;
        buttons    = 4'h0;
    endtask

    task automatic model_seed(input logic [7:0] s);
        m_lfsr = (s == 8'h00) ? 8'hA5 : s;
        colours.delete();
    endtask

    task automatic model_add();
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        colours.push_back(m_lfsr[1:0]);
    endtask

    task automatic start_new(input logic [7:0] seed);
        random_num = seed;
        model_seed(seed);
        expectOutput("seed_busy", 8'h01);
        expectOutput("seed_score", 8'h00);
        applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput({7'h0, busy});
        checkOutput(score);
        applyStimulus(1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b0, 4'h0);
        model_add();
    endtask

    task automatic play_round();
        for (int i = 0; i < colours.size(); i++) begin
            expectOutput($sformatf("show_on_%0d", i), {4'h0, onehot(colours[i])});
            checkOutput({4'h0, led});
            expectOutput($sformatf("show_hold_%0d", i), {4'h0, onehot(colours[i])});
            applyStimulus(1'b0, 1'b1, 4'h0);
            checkOutput({4'h0, led});
            expectOutput($sformatf("show_off_%0d", i), 8'h00);
            applyStimulus(1'b0, 1'b1, 4'h0);
            checkOutput({4'h0, led});
            applyStimulus(1'b0, 1'b1, 4'h0);
        end
        expectOutput("wait_led", 8'h00);
        checkOutput({4'h0, led});
        expectOutput("wait_busy", 8'h01);
        checkOutput({7'h0, busy});
    endtask

    task automatic press_round();
        for (int i = 0; i < colours.size(); i++) begin
            buttons = onehot(colours[i]);
            #1;
            expectOutput($sformatf("press_echo_%0d", i), {4'h0, onehot(colours[i])});
            checkOutput({4'h0, led});
            @(posedge clock);
            #1;
            buttons = 4'h0;
        end
        expectOutput("round_score", 8'(colours.size()));
        checkOutput(score);
        expectOutput("round_no_loss", 8'h00);
        checkOutput({7'h0, game_over});
    endtask

    task automatic next_round();
        applyStimulus(1'b0, 1'b0, 4'h0);
        model_add();
    endtask

    task automatic check_idle_outputs(input string tag);
        expectOutput({tag, "_led"}, 8'h00);
        checkOutput({4'h0, led});
        expectOutput({tag, "_score"}, 8'h00);
        checkOutput(score);
        expectOutput({tag, "_game_over"}, 8'h00);
        checkOutput({7'h0, game_over});
        expectOutput({tag, "_win"}, 8'h00);
        checkOutput({7'h0, win});
        expectOutput({tag, "_busy"}, 8'h00);
        checkOutput({7'h0, busy});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b0, 4'h0);
        check_idle_outputs("reset");
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 4'b0001);
        check_idle_outputs("idle");

        // Seed 01: first colour 2, then a correct round and a wrong press
        start_new(8'h01);
        expectOutput("seed01_led", 8'h04);
        checkOutput({4'h0, led});
        play_round();
        press_round();
        next_round();
        play_round();
        wrong_colour = colours[0] + 2'd1;
        expectOutput("wrong_game_over", 8'h01);
        expectOutput("wrong_led", 8'h0F);
        expectOutput("wrong_busy", 8'h00);
        applyStimulus(1'b0, 1'b0, onehot(wrong_colour));
        checkOutput({7'h0, game_over});
        checkOutput({4'h0, led});
        checkOutput({7'h0, busy});
        expectOutput("lose_hold", 8'h01);
        applyStimulus(1'b0, 1'b1, 4'b0001);
        checkOutput({7'h0, game_over});

        // Zero seed falls back to A5; press on the last allowed tick is accepted
        start_new(8'h00);
        expectOutput("seed00_led", 8'h04);
        checkOutput({4'h0, led});
        play_round();
        repeat (7) applyStimulus(1'b0, 1'b1, 4'h0);
        expectOutput("timeout7_alive", 8'h00);
        checkOutput({7'h0, game_over});
        expectOutput("late_press_score", 8'h01);
        expectOutput("late_press_alive", 8'h00);
        applyStimulus(1'b0, 1'b1, onehot(colours[0]));
        checkOutput(score);
        checkOutput({7'h0, game_over});
        next_round();
        play_round();
        repeat (7) applyStimulus(1'b0, 1'b1, 4'h0);
        expectOutput("timeout7_alive_r2", 8'h00);
        checkOutput({7'h0, game_over});
        expectOutput("timeout8_lose", 8'h01);
        expectOutput("timeout8_led", 8'h0F);
        applyStimulus(1'b0, 1'b1, 4'h0);
        checkOutput({7'h0, game_over});
        checkOutput({4'h0, led});

        // Full game to the maximum length
        start_new(8'h3C);
        for (int r = 1; r <= MAX_LEN; r++) begin
            play_round();
            press_round();
            if (r < MAX_LEN) next_round();
        end
        expectOutput("win_flag", 8'h01);
        checkOutput({7'h0, win});
        expectOutput("win_busy", 8'h00);
        checkOutput({7'h0, busy});
        expectOutput("win_led", 8'h0F);
        checkOutput({4'h0, led});
        expectOutput("win_hold", 8'h01);
        applyStimulus(1'b0, 1'b1, 4'b0010);
        checkOutput({7'h0, win});

        // Restart during playback, then a two-button press loses
        start_new(8'h77);
        play_round();
        press_round();
        next_round();
        random_num = 8'h5A;
        expectOutput("restart_score", 8'h00);
        expectOutput("restart_busy", 8'h01);
        expectOutput("restart_led", 8'h00);
        applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput(score);
        checkOutput({7'h0, busy});
        checkOutput({4'h0, led});
        model_seed(8'h5A);
        applyStimulus(1'b0, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b0, 4'h0);
        model_add();
        play_round();
        expectOutput("double_press_lose", 8'h01);
        applyStimulus(1'b0, 1'b0, 4'b0011);
        checkOutput({7'h0, game_over});

        // Reset while waiting for input in round two
        start_new(8'hC3);
        play_round();
        press_round();
        next_round();
        play_round();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0);
        check_idle_outputs("midgame_reset");
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 4'h0);
        expectOutput("after_reset_busy", 8'h00);
        checkOutput({7'h0, busy});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/simon_sequencer.md
SIMON_SEQUENCER -- requirements
Module: simon_sequencer

Interface
REQ-001 Parameter MAX_LEN, 32, maximum sequence length (steps); a round equal to MAX_LEN completed = win.
REQ-002 Parameter ON_TICKS, 2, tick pulses an LED stays lit per step during playback.
REQ-003 Parameter OFF_TICKS, 1, tick pulses of dark gap after each playback step.
REQ-004 Parameter TIMEOUT_TICKS, 8, tick pulses allowed between player presses before loss.
REQ-005 clock  input  1  system clock, all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 start_game  input  1  level from start button; rising edge (registered detect) starts or restarts a game.
REQ-008 random_num  input  8  seed value from the RNG register, sampled on the start_game edge.
REQ-009 tick  input  1  single-cycle timing strobe from the prescaler.
REQ-010 buttons  input  4  debounced single-cycle press pulses, one bit per colour.
REQ-011 led  output  4  one-hot colour drive (bit n = colour n).
REQ-012 score  output  8  rounds completed in the current game.
REQ-013 game_over  output  1  high in LOSE.
REQ-014 win  output  1  high in WIN.
REQ-015 busy  output  1  high in any state except IDLE, WIN, LOSE.

Function
REQ-016 States: IDLE, SEED, ADD_STEP, SHOW_ON, SHOW_OFF, WAIT_INPUT, WIN, LOSE.
REQ-017 start_game edge in any state -> SEED next cycle; len, idx, score, timeout counter cleared; led=0.
REQ-018 SEED: LFSR loaded with random_num, or 8'hA5 if random_num==0; -> ADD_STEP.
REQ-019 LFSR: 8-bit Fibonacci, feedback = b7^b5^b4^b3, shift left, feedback into b0; one step per ADD_STEP.
REQ-020 ADD_STEP: advance LFSR once, store new lfsr[1:0] at seq[len], len<=len+1, idx<=0 -> SHOW_ON.
REQ-021 SHOW_ON: led = onehot(seq[idx]); after ON_TICKS ticks -> SHOW_OFF.
REQ-022 SHOW_OFF: led=0; after OFF_TICKS ticks idx<=idx+1; if idx+1==len -> WAIT_INPUT with idx<=0, else SHOW_ON.
REQ-023 WAIT_INPUT: led echoes buttons for the press cycle; presses in other states ignored.
REQ-024 Exactly one button bit set and equal to onehot(seq[idx]) -> idx<=idx+1, timeout cleared; if idx+1==len: score<=len, then WIN if len==MAX_LEN else ADD_STEP.
REQ-025 Wrong colour or more than one bit set -> LOSE.
REQ-026 No press: timeout counter increments per tick; reaching TIMEOUT_TICKS -> LOSE; press and tick same cycle: press wins, counter cleared.
REQ-027 LOSE: game_over=1, led=4'hF; WIN: win=1, led=4'hF; both hold until start_game edge.
REQ-028 Sequence storage MAX_LEN x 2 bits; len width clog2(MAX_LEN)+1; no wrap, len never exceeds MAX_LEN.

Reset
REQ-029 reset low at clock edge: state=IDLE, led=0, score=0, game_over=0, win=0, busy=0, len=0, idx=0, LFSR=8'hA5, edge-detect register=0; reset mid-game abandons the game without output glitch beyond one cycle.

Structure
REQ-030 Shared package simon_pkg holds the state enum, colour width (2), LED width (4) and default parameter constants.
REQ-031 LFSR is a separate sub-module simon_lfsr (load, step, seed, value); storage and FSM stay in simon_sequencer.

Verification
REQ-032 random_num=8'h01, start_game edge -> first step colour 2 (LFSR 8'h02), led=4'b0100 for 2 ticks, then 0 for 1 tick, then WAIT_INPUT.
REQ-033 random_num=8'h00 -> seed 8'hA5, first LFSR value 8'h4A, led=4'b0100.
REQ-034 Round 1 correct press 4'b0100 -> score=1, ADD_STEP, 2-step playback starts; then wrong press -> game_over=1, led=4'hF.
REQ-035 No press for 8 ticks in WAIT_INPUT -> LOSE; press on 8th tick cycle -> accepted, no loss.
REQ-036 MAX_LEN=4 override, all rounds correct -> win=1, score=4, busy=0; start_game edge during SHOW_ON -> SEED, score=0.
REQ-037 reset low during WAIT_INPUT -> all outputs at reset values next cycle; buttons=4'b0011 in WAIT_INPUT -> LOSE.
